// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_if.sv
// Operand/start/result bundle between the pipeline and the multiply/divide unit.
interface multdiv_if;
  import multdiv_pkg::*;

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/twos_negate.sv
// Combinational two's complement negation: y = ~x + 1.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = ~x_i + WIDTH'(1);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide; result and one-cycle RDY strobe 33 edges after the start pulse.
// A new start pulse in any state aborts the running operation; the pipeline stalls until RDY.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic      clock,
  input  logic      reset,
  multdiv_if.slave  md
);
  import multdiv_pkg::*;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH:0]     opb_q;
  logic               sign_q;
  logic               div_zero_q;
  logic               div_ovf_q;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;

  logic               start;
  logic [WIDTH-1:0]   neg_a, neg_b, mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_neg, prod, acc_add;
  logic [WIDTH-1:0]   quo_neg, quo;
  logic               mul_ovf;
  logic [WIDTH:0]     trial;
  logic               take;
  logic [WIDTH-1:0]   diff;

  assign start = md.ctrl_MULT | md.ctrl_DIV;

  twos_negate #(.WIDTH(WIDTH)) u_neg_a (.x_i(md.data_operandA), .y_o(neg_a));
  twos_negate #(.WIDTH(WIDTH)) u_neg_b (.x_i(md.data_operandB), .y_o(neg_b));

  // Unsigned magnitudes; 0x80000000 maps to 2^31, which still fits unsigned WIDTH bits.
  assign mag_a = md.data_operandA[WIDTH-1] ? neg_a : md.data_operandA;
  assign mag_b = md.data_operandB[WIDTH-1] ? neg_b : md.data_operandB;

  twos_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.x_i(acc_q), .y_o(prod_neg));
  twos_negate #(.WIDTH(WIDTH))   u_neg_quo  (.x_i(acc_q[WIDTH-1:0]), .y_o(quo_neg));

  assign prod    = sign_q ? prod_neg : acc_q;
  assign quo     = sign_q ? quo_neg  : acc_q[WIDTH-1:0];
  assign mul_ovf = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
  assign acc_add = opb_q[0] ? (acc_q + mcand_q) : acc_q;

  // Divide: acc_q holds {remainder, dividend/quotient}; shift one dividend bit into the remainder.
  assign trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign take  = trial >= opb_q;
  assign diff  = trial[WIDTH-1:0] - opb_q[WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      opb_q      <= '0;
      sign_q     <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_q   <= '0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        state_q    <= md.ctrl_MULT ? MUL_RUN : DIV_RUN;
        cnt_q      <= '0;
        acc_q      <= md.ctrl_MULT ? '0 : {{WIDTH{1'b0}}, mag_a};
        mcand_q    <= {{WIDTH{1'b0}}, mag_a};
        opb_q      <= {1'b0, mag_b};
        sign_q     <= md.data_operandA[WIDTH-1] ^ md.data_operandB[WIDTH-1];
        div_zero_q <= md.data_operandB == '0;
        div_ovf_q  <= (md.data_operandA == MIN_NEG) && (md.data_operandB == '1);
      end else begin
        case (state_q)
          MUL_RUN: begin
            if (cnt_q == CNT_W'(ITER)) begin
              result_q <= prod[WIDTH-1:0];
              exc_q    <= mul_ovf;
              rdy_q    <= 1'b1;
              state_q  <= DONE;
            end else begin
              acc_q   <= acc_add;
              mcand_q <= mcand_q << 1;
              opb_q   <= opb_q >> 1;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
          DIV_RUN: begin
            if (cnt_q == CNT_W'(ITER)) begin
              result_q <= div_zero_q ? '0 : quo;
              exc_q    <= div_zero_q | div_ovf_q;
              rdy_q    <= 1'b1;
              state_q  <= DONE;
            end else begin
              acc_q <= take ? {diff, acc_q[WIDTH-2:0], 1'b1}
                            : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign md.data_result    = result_q;
  assign md.data_exception = exc_q;
  assign md.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized scoreboard bench for multdiv_unit against a plain-arithmetic reference model.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multdiv_if md ();

  multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock (clock),
    .reset (reset),
    .md    (md)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          issue;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [31:0] held_res = '0;
  logic        held_exc = 1'b0;
  logic        prev_rdy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint p;
    r.issue = 0;
    if (m) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      r.res = p[31:0];
      r.exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'h0) begin
      r.res = 32'h0;
      r.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.res = 32'h8000_0000;
      r.exc = 1'b1;
    end else begin
      p     = longint'($signed(a)) / longint'($signed(b));
      r.res = p[31:0];
      r.exc = 1'b0;
    end
    return r;
  endfunction

  // Monitor: every cycle either a strobed result matching the scoreboard, or held outputs.
  always @(negedge clock) begin
    if (!reset) begin
      if (md.data_resultRDY) begin
        chk("rdy_width", {63'b0, prev_rdy}, 64'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_rdy", {63'b0, md.data_resultRDY}, 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("result", {32'b0, md.data_result}, {32'b0, mon_e.res});
          chk("exception", {63'b0, md.data_exception}, {63'b0, mon_e.exc});
          chk("latency", 64'(cyc - mon_e.issue), 64'd33);
          held_res = mon_e.res;
          held_exc = mon_e.exc;
        end
      end else begin
        chk("hold_result", {32'b0, md.data_result}, {32'b0, held_res});
        chk("hold_exception", {63'b0, md.data_exception}, {63'b0, held_exc});
      end
      prev_rdy = md.data_resultRDY;
    end else begin
      prev_rdy = 1'b0;
    end
  end

  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(posedge clock);
    #2;
    md.data_operandA = a;
    md.data_operandB = b;
    md.ctrl_MULT     = m;
    md.ctrl_DIV      = d;
    e       = model(m, a, b);
    e.issue = cyc + 1;
    // An operation whose E33 is not yet past when this pulse is sampled is aborted.
    while (sbq.size() > 0 && sbq[$].issue + 33 >= e.issue) void'(sbq.pop_back());
    sbq.push_back(e);
    @(posedge clock);
    #2;
    md.ctrl_MULT = 1'b0;
    md.ctrl_DIV  = 1'b0;
  endtask

  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    start_op(m, d, a, b);
    repeat (34) @(posedge clock);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = $urandom_range(0, 20) - 10;
      4:       v = $urandom_range(0, 32'hFFFF) - 32'h8000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  localparam int NDIR = 8;
  bit          dir_m[NDIR] = '{1, 1, 1, 0, 0, 0, 0, 1};
  bit          dir_d[NDIR] = '{0, 0, 0, 1, 1, 1, 1, 1};
  logic [31:0] dir_a[NDIR] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                               32'd100, 32'd5, 32'h8000_0000, 32'd6};
  logic [31:0] dir_b[NDIR] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1, 32'd2,
                               32'd7, 32'd0, 32'hFFFF_FFFF, 32'd3};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached with %0d results outstanding", sbq.size());
    $fatal(1);
  end

  initial begin
    md.data_operandA = '0;
    md.data_operandB = '0;
    md.ctrl_MULT     = 1'b0;
    md.ctrl_DIV      = 1'b0;
    #1;
    chk("reset_result", {32'b0, md.data_result}, 64'd0);
    chk("reset_exception", {63'b0, md.data_exception}, 64'd0);
    chk("reset_rdy", {63'b0, md.data_resultRDY}, 64'd0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    for (int i = 0; i < NDIR; i++) run_op(dir_m[i], dir_d[i], dir_a[i], dir_b[i]);

    // Restart: the DIV pulse 10 cycles after the MULT pulse replaces it.
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (8) @(posedge clock);
    run_op(1'b0, 1'b1, 32'd100, 32'd7);

    // Back-to-back: next pulse lands in the RDY cycle.
    start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (32) @(posedge clock);
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);

    // Asynchronous reset part-way through an operation.
    start_op(1'b1, 1'b0, 32'd12345, 32'd678);
    repeat (19) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_result", {32'b0, md.data_result}, 64'd0);
    chk("async_reset_exception", {63'b0, md.data_exception}, 64'd0);
    chk("async_reset_rdy", {63'b0, md.data_resultRDY}, 64'd0);
    sbq.delete();
    held_res = '0;
    held_exc = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    repeat (40) @(posedge clock);
    run_op(1'b1, 1'b0, 32'd2, 32'd2);

    for (int i = 0; i < 40; i++) begin
      int sel;
      int gap;
      sel = $urandom_range(0, 2);
      start_op(sel != 1, sel != 0, rnd_operand(), rnd_operand());
      gap = ($urandom_range(0, 3) == 0) ? 32 : $urandom_range(0, 45);
      repeat (gap) @(posedge clock);
    end

    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(posedge clock);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
    end
    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
